// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: owns the HI/LO registers and runs the multi-cycle
// MULT/MULTU/DIV/DIVU operations for the EX stage. Operands are reduced to
// magnitudes on acceptance. The multiply is shift-add and the divide is
// restoring. Signs are re-applied in a single FIX cycle before HI/LO are
// written.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             RstN,
    input  logic             Start,
    input  logic [5:0]       FuncCode,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             Flush,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0]   iter_cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH:0]     rem;
    logic               res_sign;
    logic               rem_sign;
    logic               op_div;
    logic               done_q;

    logic               is_mul;
    logic               is_div;
    logic               is_mthi;
    logic               is_mtlo;
    logic               func_valid;
    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic               b_zero;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               last_iter;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH+1:0]   div_shift;
    logic [WIDTH+1:0]   div_trial;
    logic [WIDTH:0]     rem_next;
    logic [WIDTH-1:0]   quot_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;

    // Decode the funct field into the HI/LO instruction classes.
    always_comb begin
        is_mul     = 1'b0;
        is_div     = 1'b0;
        is_mthi    = 1'b0;
        is_mtlo    = 1'b0;
        func_valid = 1'b0;
        case (FuncCode)
            6'b011000, 6'b011001: begin
                is_mul     = 1'b1;
                func_valid = 1'b1;
            end
            6'b011010, 6'b011011: begin
                is_div     = 1'b1;
                func_valid = 1'b1;
            end
            6'b010001: begin
                is_mthi    = 1'b1;
                func_valid = 1'b1;
            end
            6'b010011: begin
                is_mtlo    = 1'b1;
                func_valid = 1'b1;
            end
            6'b010000, 6'b010010: func_valid = 1'b1;
            default: func_valid = 1'b0;
        endcase
    end

    // Operand magnitudes and signs; the signed variants have funct bit 0 clear.
    always_comb begin
        signed_op = ~FuncCode[0];
        a_neg     = signed_op & SrcA[WIDTH-1];
        b_neg     = signed_op & SrcB[WIDTH-1];
        mag_a     = a_neg ? -SrcA : SrcA;
        mag_b     = b_neg ? -SrcB : SrcB;
        b_zero    = (SrcB == '0);
        last_iter = (iter_cnt == LAST_ITER);
    end

    // One shift-add multiply step and one restoring divide step.
    always_comb begin
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        mul_next  = {mul_sum, prod[WIDTH-1:1]};
        div_shift = {rem, quot[WIDTH-1]};
        div_trial = div_shift - {2'b00, divisor};
        if (!div_trial[WIDTH+1]) begin
            rem_next  = div_trial[WIDTH:0];
            quot_next = {quot[WIDTH-2:0], 1'b1};
        end else begin
            rem_next  = div_shift[WIDTH:0];
            quot_next = {quot[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction of the finished result, selected by operation type.
    always_comb begin
        prod_fix = res_sign ? -prod : prod;
        if (op_div) begin
            hi_fix = rem_sign ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
            lo_fix = res_sign ? -quot : quot;
        end else begin
            hi_fix = prod_fix[2*WIDTH-1:WIDTH];
            lo_fix = prod_fix[WIDTH-1:0];
        end
    end

    // Next-state logic; flush wins over everything else.
    always_comb begin
        next_state = state;
        if (Flush) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (Start && is_mul) begin
                        next_state = MUL;
                    end else if (Start && is_div) begin
                        next_state = b_zero ? FIX : DIV;
                    end
                end
                MUL:     if (last_iter) next_state = FIX;
                DIV:     if (last_iter) next_state = FIX;
                FIX:     next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath registers: operand capture, iterations, HI/LO writes, Done pulse.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            iter_cnt <= '0;
            mcand    <= '0;
            prod     <= '0;
            divisor  <= '0;
            quot     <= '0;
            rem      <= '0;
            res_sign <= 1'b0;
            rem_sign <= 1'b0;
            op_div   <= 1'b0;
            done_q   <= 1'b0;
            Hi       <= '0;
            Lo       <= '0;
        end else begin
            done_q <= 1'b0;
            if (!Flush) begin
                case (state)
                    IDLE: begin
                        if (Start && is_mthi) Hi <= SrcA;
                        if (Start && is_mtlo) Lo <= SrcA;
                        if (Start && (is_mul || is_div)) begin
                            iter_cnt <= '0;
                            op_div   <= is_div;
                            res_sign <= a_neg ^ b_neg;
                            rem_sign <= a_neg;
                            mcand    <= mag_a;
                            prod     <= {{WIDTH{1'b0}}, mag_b};
                            divisor  <= mag_b;
                            quot     <= mag_a;
                            rem      <= '0;
                            if (is_div && b_zero) begin
                                res_sign <= 1'b0;
                                rem_sign <= 1'b0;
                                quot     <= '1;
                                rem      <= {1'b0, SrcA};
                            end
                        end
                    end
                    MUL: begin
                        prod     <= mul_next;
                        iter_cnt <= iter_cnt + CNT_W'(1);
                    end
                    DIV: begin
                        rem      <= rem_next;
                        quot     <= quot_next;
                        iter_cnt <= iter_cnt + CNT_W'(1);
                    end
                    FIX: begin
                        Hi     <= hi_fix;
                        Lo     <= lo_fix;
                        done_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Status outputs; Stall is purely combinational so independent ALU ops flow.
    always_comb begin
        Busy  = (state != IDLE);
        Stall = Start & func_valid & Busy;
        Done  = done_q;
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: randomized and directed checks of the HI/LO sequencer
// against a plain-arithmetic reference model.
module tb_muldiv_sequencer;

    localparam int WIDTH = 32;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_ADD   = 6'b100000;

    logic             Clk;
    logic             RstN;
    logic             Start;
    logic [5:0]       FuncCode;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             Flush;
    logic             Busy;
    logic             Stall;
    logic             Done;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    muldiv_sequencer #(.WIDTH(WIDTH)) dut (
        .Clk(Clk), .RstN(RstN), .Start(Start), .FuncCode(FuncCode),
        .SrcA(SrcA), .SrcB(SrcB), .Flush(Flush), .Busy(Busy),
        .Stall(Stall), .Done(Done), .Hi(Hi), .Lo(Lo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference: {HI, LO} of a multiply/divide from plain 64-bit arithmetic.
    function automatic logic [63:0] model_hilo(input logic [5:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        model_hilo = '0;
        case (f)
            F_MULTU: model_hilo = ua * ub;
            F_MULT:  model_hilo = 64'(sa * sb);
            F_DIVU: begin
                if (b == 0) model_hilo = {a, 32'hFFFFFFFF};
                else        model_hilo = {a % b, a / b};
            end
            F_DIV: begin
                if (b == 0) begin
                    model_hilo = {a, 32'hFFFFFFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    model_hilo = {32'(r), 32'(q)};
                end
            end
            default: model_hilo = '0;
        endcase
    endfunction

    function automatic int model_latency(input logic [5:0] f, input logic [31:0] b);
        if ((f == F_DIV || f == F_DIVU) && b == 0) return 1;
        return 33;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Present one operation, release Start after acceptance, wait (bounded) for Done.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        Start    = 1'b1;
        FuncCode = f;
        SrcA     = a;
        SrcB     = b;
        tick();
        Start    = 1'b0;
        FuncCode = F_ADD;
        lat      = 0;
        while (Done !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        Flush    = 1'b0;
        Start    = 1'b1;
        FuncCode = F_MULT;
        SrcA     = 32'h5;
        SrcB     = 32'h7;
        RstN     = 1'b1;
        #1 RstN  = 1'b0;
        #6;
        vectors++; if (Busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b expected 0", Busy); end
        vectors++; if (Done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b expected 0", Done); end
        vectors++; if (Stall !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall got %b expected 0", Stall); end
        vectors++; if (Hi !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_hi got %h expected 0", Hi); end
        vectors++; if (Lo !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_lo got %h expected 0", Lo); end
        #1;
        Start = 1'b0;
        RstN  = 1'b1;
        tick();
    endtask

    task automatic test_multu_max();
        int lat;
        run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        {exp_hi, exp_lo} = 64'hFFFFFFFE_00000001;
        vectors++; if (lat !== 33) begin miscompares++; $display("[TB] FAIL multu_latency got %0d expected 33", lat); end
        vectors++; if (Hi !== exp_hi) begin miscompares++; $display("[TB] FAIL multu_hi got %h expected %h", Hi, exp_hi); end
        vectors++; if (Lo !== exp_lo) begin miscompares++; $display("[TB] FAIL multu_lo got %h expected %h", Lo, exp_lo); end
        tick();
        vectors++; if (Done !== 1'b0) begin miscompares++; $display("[TB] FAIL done_pulse got %b expected 0", Done); end
    endtask

    task automatic test_mult_stall();
        int cyc;
        int bad;
        Start    = 1'b1;
        FuncCode = F_MULT;
        SrcA     = 32'hFFFFFFFD;
        SrcB     = 32'h00000007;
        tick();
        FuncCode = F_MFHI;
        cyc = 0;
        bad = 0;
        while (Done !== 1'b1 && cyc < 100) begin
            if (Stall !== 1'b1) bad++;
            tick();
            cyc++;
        end
        exp_hi = 32'hFFFFFFFF;
        exp_lo = 32'hFFFFFFEB;
        vectors++; if (bad !== 0) begin miscompares++; $display("[TB] FAIL mfhi_stall cycles_without_stall got %0d expected 0", bad); end
        vectors++; if (cyc !== 33) begin miscompares++; $display("[TB] FAIL mult_latency got %0d expected 33", cyc); end
        vectors++; if (Stall !== 1'b0) begin miscompares++; $display("[TB] FAIL mfhi_done_stall got %b expected 0", Stall); end
        vectors++; if (Hi !== exp_hi) begin miscompares++; $display("[TB] FAIL mult_hi got %h expected %h", Hi, exp_hi); end
        vectors++; if (Lo !== exp_lo) begin miscompares++; $display("[TB] FAIL mult_lo got %h expected %h", Lo, exp_lo); end
        Start = 1'b0;
        tick();
    endtask

    task automatic test_divide();
        int lat;
        run_op(F_DIV, 32'hFFFFFFF9, 32'h00000002, lat);
        exp_hi = 32'hFFFFFFFF;
        exp_lo = 32'hFFFFFFFD;
        vectors++; if (lat !== 33) begin miscompares++; $display("[TB] FAIL div_latency got %0d expected 33", lat); end
        vectors++; if (Hi !== exp_hi) begin miscompares++; $display("[TB] FAIL div_hi got %h expected %h", Hi, exp_hi); end
        vectors++; if (Lo !== exp_lo) begin miscompares++; $display("[TB] FAIL div_lo got %h expected %h", Lo, exp_lo); end
        run_op(F_DIVU, 32'h12345678, 32'h0, lat);
        exp_hi = 32'h12345678;
        exp_lo = 32'hFFFFFFFF;
        vectors++; if (lat !== 1) begin miscompares++; $display("[TB] FAIL divzero_latency got %0d expected 1", lat); end
        vectors++; if (Hi !== exp_hi) begin miscompares++; $display("[TB] FAIL divzero_hi got %h expected %h", Hi, exp_hi); end
        vectors++; if (Lo !== exp_lo) begin miscompares++; $display("[TB] FAIL divzero_lo got %h expected %h", Lo, exp_lo); end
        run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, lat);
        exp_hi = 32'h00000000;
        exp_lo = 32'h80000000;
        vectors++; if (Hi !== exp_hi) begin miscompares++; $display("[TB] FAIL overflow_hi got %h expected %h", Hi, exp_hi); end
        vectors++; if (Lo !== exp_lo) begin miscompares++; $display("[TB] FAIL overflow_lo got %h expected %h", Lo, exp_lo); end
        tick();
    endtask

    task automatic test_flush();
        int lat;
        int done_seen;
        Start    = 1'b1;
        FuncCode = F_MTLO;
        SrcA     = 32'h0000ABCD;
        tick();
        Start    = 1'b0;
        exp_lo   = 32'h0000ABCD;
        vectors++; if (Lo !== exp_lo) begin miscompares++; $display("[TB] FAIL mtlo_lo got %h expected %h", Lo, exp_lo); end
        vectors++; if (Busy !== 1'b0 || Done !== 1'b0) begin miscompares++; $display("[TB] FAIL mtlo_status got busy=%b done=%b expected 0 0", Busy, Done); end
        Start    = 1'b1;
        FuncCode = F_MULT;
        SrcA     = 32'd2;
        SrcB     = 32'd3;
        tick();
        Start    = 1'b0;
        repeat (10) tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        vectors++; if (Busy !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_busy got %b expected 0", Busy); end
        vectors++; if (Lo !== exp_lo || Hi !== exp_hi) begin miscompares++; $display("[TB] FAIL flush_hilo got %h_%h expected %h_%h", Hi, Lo, exp_hi, exp_lo); end
        done_seen = 0;
        repeat (40) begin
            tick();
            if (Done === 1'b1) done_seen++;
        end
        vectors++; if (done_seen !== 0) begin miscompares++; $display("[TB] FAIL flush_done got %0d pulses expected 0", done_seen); end
        Start    = 1'b1;
        FuncCode = F_MULT;
        SrcA     = 32'd5;
        SrcB     = 32'd5;
        tick();
        Start    = 1'b0;
        repeat (32) tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        vectors++; if (Done !== 1'b0 || Busy !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_fix got done=%b busy=%b expected 0 0", Done, Busy); end
        vectors++; if (Lo !== exp_lo) begin miscompares++; $display("[TB] FAIL flush_fix_lo got %h expected %h", Lo, exp_lo); end
        Start    = 1'b1;
        FuncCode = F_MTHI;
        SrcA     = 32'hDEADBEEF;
        Flush    = 1'b1;
        tick();
        Start    = 1'b0;
        Flush    = 1'b0;
        vectors++; if (Hi !== exp_hi) begin miscompares++; $display("[TB] FAIL flush_mthi got %h expected %h", Hi, exp_hi); end
        run_op(F_MULT, 32'd2, 32'd3, lat);
        exp_hi = 32'd0;
        exp_lo = 32'd6;
        vectors++; if (lat !== 33) begin miscompares++; $display("[TB] FAIL remult_latency got %0d expected 33", lat); end
        vectors++; if (Lo !== exp_lo || Hi !== exp_hi) begin miscompares++; $display("[TB] FAIL remult_hilo got %h_%h expected %h_%h", Hi, Lo, exp_hi, exp_lo); end
        tick();
    endtask

    task automatic test_reset_mid();
        Start    = 1'b1;
        FuncCode = F_DIV;
        SrcA     = $urandom;
        SrcB     = $urandom_range(1, 1000);
        tick();
        Start    = 1'b0;
        repeat (5) tick();
        RstN = 1'b0;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        vectors++; if (Busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_busy got %b expected 0", Busy); end
        vectors++; if (Hi !== exp_hi || Lo !== exp_lo) begin miscompares++; $display("[TB] FAIL midreset_hilo got %h_%h expected 0_0", Hi, Lo); end
        vectors++; if (Done !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_done got %b expected 0", Done); end
        #2 RstN = 1'b1;
        tick();
    endtask

    task automatic test_stall_rules();
        logic [31:0] a, b;
        logic [63:0] res;
        int cyc;
        a = $urandom;
        b = $urandom;
        Start    = 1'b1;
        FuncCode = F_MULT;
        SrcA     = a;
        SrcB     = b;
        tick();
        FuncCode = F_ADD;
        SrcA     = 32'h55AA55AA;
        #1;
        vectors++; if (Stall !== 1'b0) begin miscompares++; $display("[TB] FAIL add_stall got %b expected 0", Stall); end
        FuncCode = F_MTLO;
        #1;
        vectors++; if (Stall !== 1'b1) begin miscompares++; $display("[TB] FAIL mtlo_busy_stall got %b expected 1", Stall); end
        tick();
        tick();
        Start = 1'b0;
        cyc = 0;
        while (Done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        res = model_hilo(F_MULT, a, b);
        {exp_hi, exp_lo} = res;
        vectors++; if (Hi !== exp_hi || Lo !== exp_lo) begin miscompares++; $display("[TB] FAIL stalled_mtlo_hilo got %h_%h expected %h_%h", Hi, Lo, exp_hi, exp_lo); end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  ops [4];
        logic [5:0]  f;
        logic [31:0] a, b;
        int lat;
        ops[0] = F_MULT;
        ops[1] = F_MULTU;
        ops[2] = F_DIV;
        ops[3] = F_DIVU;
        for (int i = 0; i < 24; i++) begin
            f = ops[$urandom_range(0, 3)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = $urandom_range(1, 9);
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: a = $urandom_range(0, 50);
                default: ;
            endcase
            if (Done === 1'b1) begin
                Start    = 1'b1;
                FuncCode = F_MFHI;
                #1;
                vectors++; if (Stall !== 1'b0 || Hi !== exp_hi) begin miscompares++; $display("[TB] FAIL b2b_mfhi got stall=%b hi=%h expected 0 %h", Stall, Hi, exp_hi); end
            end
            run_op(f, a, b, lat);
            {exp_hi, exp_lo} = model_hilo(f, a, b);
            vectors++; if (lat !== model_latency(f, b)) begin miscompares++; $display("[TB] FAIL rand_latency f=%b got %0d expected %0d", f, lat, model_latency(f, b)); end
            vectors++; if (Hi !== exp_hi) begin miscompares++; $display("[TB] FAIL rand_hi f=%b a=%h b=%h got %h expected %h", f, a, b, Hi, exp_hi); end
            vectors++; if (Lo !== exp_lo) begin miscompares++; $display("[TB] FAIL rand_lo f=%b a=%h b=%h got %h expected %h", f, a, b, Lo, exp_lo); end
        end
        tick();
    endtask

    initial begin
        Start    = 1'b0;
        FuncCode = F_ADD;
        SrcA     = '0;
        SrcB     = '0;
        Flush    = 1'b0;
        RstN     = 1'b1;
        test_reset();
        test_multu_max();
        test_mult_stall();
        test_divide();
        test_flush();
        test_reset_mid();
        test_stall_rules();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
